// File: rtl/mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_arbiter_pkg
// Shared definitions for the 4-channel round-robin mux arbiter:
//   - FSM state encoding (IDLE = 0, GRANT = 1)
//   - channel count, channel-index (sel) width, hold-counter width
//   - small helpers for channel-index arithmetic and port bit-order mapping
// ---------------------------------------------------------------------------
package mux_arbiter_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;
  // Hold counter must cover MAX_HOLD-1 for MAX_HOLD up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // Next channel in round-robin order, wrapping 3 -> 0.
  function automatic ch_idx_t ch_next(input ch_idx_t c);
    return c + SEL_W'(1);
  endfunction

  // Port-side channel indices are declared [0:1] with bit 0 as the LSB;
  // internally indices are conventional [1:0]. These map between the two.
  function automatic ch_idx_t idx_from_port(input logic [0:1] p);
    return {p[1], p[0]};
  endfunction

  function automatic logic [0:1] idx_to_port(input ch_idx_t v);
    logic [0:1] p;
    p[0] = v[0];
    p[1] = v[1];
    return p;
  endfunction

endpackage : mux_arbiter_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search over four request lines.
// Starting at channel 'start', walks upward with wrap-around and reports the
// first channel whose request is high.
// Ports:
//   req   [0:3] in   request per channel, bit i = channel i
//   start [0:1] in   first channel to examine (start[0] is the LSB)
//   found       out  at least one request is high
//   idx   [0:1] out  winning channel (idx[0] is the LSB); 0 when !found
// ---------------------------------------------------------------------------
module rr_pick
  import mux_arbiter_pkg::*;
(
  input  logic [0:N_CH-1]  req,
  input  logic [0:SEL_W-1] start,
  output logic             found,
  output logic [0:SEL_W-1] idx
);

  ch_idx_t start_v;
  ch_idx_t ch;
  ch_idx_t idx_v;
  logic    found_c;

  assign start_v = idx_from_port(start);

  // First requester at or after start_v, in wrapping upward order.
  always_comb begin
    found_c = 1'b0;
    idx_v   = '0;
    ch      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch = start_v + SEL_W'(k);
      if (!found_c && req[ch]) begin
        found_c = 1'b1;
        idx_v   = ch;
      end
    end
  end

  assign found = found_c;
  assign idx   = idx_to_port(idx_v);

endmodule : rr_pick

// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
// Four-channel round-robin arbiter with a registered-select 4:1 data mux.
// A granted channel keeps ownership for up to MAX_HOLD accepted transfers,
// or until it drops its request; then the arbiter re-arbitrates in the same
// cycle so a new owner (possibly the same one) follows with no idle bubble.
// Parameters:
//   WIDTH     data width of each channel and of out_data
//   MAX_HOLD  transfers per grant before forced re-arbitration (1..15)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req   [0:3]       per-channel request (bit i = channel i)
//   in0..in3          channel data
//   out_ready         downstream accepts out_data this cycle
//   out_valid         req of the owner while granted (combinational)
//   out_data          data of channel sel while granted, else 0
//   grant [0:3]       one-hot owner while granted, else 0
//   sel   [0:1]       registered owner index (sel[0] is the LSB)
//   busy              high while granted
// ---------------------------------------------------------------------------
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:N_CH-1]  req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [0:N_CH-1]  grant,
  output logic [0:SEL_W-1] sel,
  output logic             busy
);

  state_e           state_q, state_d;
  ch_idx_t          sel_q, sel_d;
  ch_idx_t          last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             owner_req;
  logic             transfer;
  logic             hold_done;
  logic             release_c;
  logic [0:N_CH-1]  pick_req;
  logic [0:SEL_W-1] pick_start;
  logic             pick_found;
  logic [0:SEL_W-1] pick_idx_p;
  ch_idx_t          pick_idx;
  logic [WIDTH-1:0] sel_data;

  // Ownership bookkeeping derived from the current owner.
  assign owner_req = req[sel_q];
  assign transfer  = (state_q == ST_GRANT) && owner_req && out_ready;
  assign hold_done = transfer && (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign release_c = (state_q == ST_GRANT) && (hold_done || !owner_req);

  // Owner is excluded from the search when it has dropped its request; on a
  // hold expiry it stays eligible but is examined last, so a sole requester
  // is simply re-granted.
  always_comb begin
    pick_req = req;
    if ((state_q == ST_GRANT) && !owner_req) begin
      pick_req[sel_q] = 1'b0;
    end
  end

  assign pick_start = idx_to_port(ch_next(last_owner_q));
  assign pick_idx   = idx_from_port(pick_idx_p);

  rr_pick u_rr_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx_p)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      last_owner_q <= SEL_W'(N_CH - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: grant issue, hold counting, release and re-arbitration.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d      = ST_GRANT;
          sel_d        = pick_idx;
          last_owner_d = pick_idx;
          cnt_d        = '0;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          if (pick_found) begin
            state_d      = ST_GRANT;
            sel_d        = pick_idx;
            last_owner_d = pick_idx;
            cnt_d        = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (transfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // 4:1 data select, steered only by the registered owner index.
  always_comb begin
    case (sel_q)
      2'd0:    sel_data = in0;
      2'd1:    sel_data = in1;
      2'd2:    sel_data = in2;
      default: sel_data = in3;
    endcase
  end

  // Output decode from state and owner.
  always_comb begin
    grant     = '0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    if (state_q == ST_GRANT) begin
      grant[sel_q] = 1'b1;
      busy         = 1'b1;
      out_valid    = owner_req;
      out_data     = sel_data;
    end
  end

  assign sel = idx_to_port(sel_q);

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_arbiter
// Self-checking bench for mux_arbiter: directed scenarios followed by random
// request/ready/data traffic, every cycle compared against a behavioural
// model of owner, transfers-held count and round-robin pointer.
// ---------------------------------------------------------------------------
module tb_mux_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned MH = 4;

  logic         clk;
  logic         rst_n;
  logic [0:3]   req;
  logic [W-1:0] in0, in1, in2, in3;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [0:3]   grant;
  logic [0:1]   sel;
  logic         busy;

  int n_tests;
  int n_fail;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_last;
  int m_held;

  mux_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First requester scanning upward from last+1, wrapping; -1 if none.
  function automatic int rr_win(input logic [0:3] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] chan_data(input int c);
    case (c)
      0:       return in0;
      1:       return in1;
      2:       return in2;
      default: return in3;
    endcase
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 3;
    m_held  = 0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_clock();
    int w;
    logic [0:3] pr;
    if (!m_busy) begin
      w = rr_win(req, m_last);
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_last  = w;
        m_held  = 0;
      end
    end else begin
      if (req[m_owner] && out_ready) m_held++;
      if (!req[m_owner] || m_held == MH) begin
        pr = req;
        if (!req[m_owner]) pr[m_owner] = 1'b0;
        w = rr_win(pr, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_held  = 0;
        end else begin
          m_busy = 1'b0;
          m_held = 0;
        end
      end
    end
  endtask

  // Entered at posedge+1: apply inputs, check settled outputs, advance.
  task automatic step(input string ph, input logic [0:3] r, input logic rdy);
    logic [0:3] g_exp;
    logic [1:0] sel_got;
    req       = r;
    out_ready = rdy;
    in0       = W'($urandom);
    in1       = W'($urandom);
    in2       = W'($urandom);
    in3       = W'($urandom);
    #2;
    g_exp = '0;
    if (m_busy) g_exp[m_owner] = 1'b1;
    sel_got = {sel[1], sel[0]};
    check_eq({ph, ".grant"}, 32'(grant), 32'(g_exp));
    check_eq({ph, ".busy"},  32'(busy),  32'(m_busy));
    check_eq({ph, ".valid"}, 32'(out_valid), m_busy ? 32'(req[m_owner]) : 32'd0);
    check_eq({ph, ".data"},  32'(out_data),  m_busy ? 32'(chan_data(m_owner)) : 32'd0);
    check_eq({ph, ".sel"},   32'(sel_got),   32'(m_owner));
    model_clock();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1: assert reset mid-cycle, check outputs clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst.grant", 32'(grant), 32'd0);
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.busy",  32'(busy), 32'd0);
    check_eq("rst.data",  32'(out_data), 32'd0);
    check_eq("rst.sel",   32'({sel[1], sel[0]}), 32'd0);
    req       = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:3] r;
    logic [0:3] prev;
    int         mode;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Sole requester ch0: grant after one cycle, re-grant every MAX_HOLD.
    for (int i = 0; i < 11; i++) step("solo0", 4'b1000, 1'b1);

    // All requesting: ch0..ch3 then ch0 again, MAX_HOLD cycles each.
    do_reset();
    for (int i = 0; i < 20; i++) step("all", 4'b1111, 1'b1);

    // Owner ch2 stalled for 5 cycles keeps the grant, then drains.
    do_reset();
    step("stall", 4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) step("stall", 4'b0011, 1'b0);
    for (int i = 0; i < 6; i++) step("stall", 4'b0011, 1'b1);

    // Owner ch1 drops after 2 transfers with ch3 pending.
    do_reset();
    step("drop", 4'b0100, 1'b1);
    step("drop", 4'b0101, 1'b1);
    step("drop", 4'b0101, 1'b1);
    for (int i = 0; i < 3; i++) step("drop", 4'b0001, 1'b1);

    // Reset mid-grant on ch2, then 0110 goes to ch1 first.
    do_reset();
    step("rstmid", 4'b0010, 1'b1);
    step("rstmid", 4'b0010, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) step("rstmid", 4'b0110, 1'b1);

    // Owner ch3 releasing with only ch0 pending wraps to ch0.
    do_reset();
    step("wrap", 4'b0001, 1'b1);
    step("wrap", 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) step("wrap", 4'b1000, 1'b1);
    step("wrap", 4'b0000, 1'b1);
    step("wrap", 4'b0000, 1'b1);

    // Random traffic in several request-density regimes.
    prev = '0;
    for (int i = 0; i < 2000; i++) begin
      mode = (i / 200) % 4;
      case (mode)
        0:       r = prev ^ (($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000);
        1:       r = 4'($urandom) & 4'($urandom);
        2:       r = 4'($urandom) | 4'($urandom);
        default: r = 4'($urandom);
      endcase
      prev = r;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step("rand", r, (mode == 3) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_arbiter

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data channel and of out_data.
REQ-002 Parameter MAX_HOLD, default 4, legal range 1..15: maximum accepted transfers per grant before the arbiter re-arbitrates.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req  input  [0:3]  request per channel; bit i belongs to channel i.
REQ-006 in0, in1, in2, in3  input  WIDTH each  channel data.
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_data  output  WIDTH  data of the granted channel.
REQ-010 grant  output  [0:3]  one-hot granted channel; all zero when no channel is granted.
REQ-011 sel  output  [0:1]  registered index of the granted channel; sel[0] is the LSB.
REQ-012 busy  output  1  high while in state GRANT.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 IDLE, any req bit high: next cycle -> GRANT, owner = round-robin winner (REQ-017), hold count = 0.
REQ-015 IDLE, req = 0: stay in IDLE.
REQ-016 In IDLE, outputs SHALL be grant = 0, out_valid = 0, and busy = 0; sel SHALL hold its last value.
REQ-017 Round-robin search SHALL start at channel (last_owner+1) mod 4 and continue upward with wrap; the first channel with req high wins.
REQ-018 In GRANT: grant = one-hot(owner), busy = 1, and out_valid = req[owner], combinationally and with no register.
REQ-019 out_data SHALL equal the input selected by sel whenever state is GRANT; otherwise it SHALL be 0.
REQ-020 Transfer = out_valid & out_ready; each transfer increments the hold count.
REQ-021 Stall: out_valid = 1 and out_ready = 0. A stall SHALL leave the count unchanged and SHALL NOT release the grant.
REQ-022 Release condition: (transfer and count == MAX_HOLD-1) or req[owner] == 0.
REQ-023 On release, the arbiter SHALL re-arbitrate in the same cycle, over req with the owner bit masked when the owner's req is low.
REQ-024 Re-arbitration with a winner: next cycle stay in GRANT with the new owner, count = 0, and no idle bubble.
REQ-025 Re-arbitration with no winner: next cycle -> IDLE.
REQ-026 Sole requester reaching MAX_HOLD: it SHALL be re-granted back-to-back, with count cleared.
REQ-027 req changes on non-owner channels SHALL NOT affect the current grant until release.
REQ-028 last_owner SHALL update only when a grant is issued.
REQ-029 The transfer latency from a req to out_valid SHALL be exactly 1 cycle from IDLE.

Reset
REQ-030 rst_n low SHALL immediately force: state = IDLE, grant = 0, sel = 0, count = 0, last_owner = 3 (so channel 0 has first priority), out_valid = 0, out_data = 0, busy = 0.
REQ-031 Reset mid-grant SHALL abort the grant with no completion transfer; the first grant after reset release SHALL follow REQ-014.

Structure
REQ-032 A shared package SHALL hold: the state encoding (IDLE = 0, GRANT = 1), N_CH = 4, and the sel width = 2.
REQ-033 The rotating-priority search SHALL be one combinational sub-module, rr_pick, with inputs req[0:3] and start[0:1] and outputs found and idx[0:1].
REQ-034 The data path SHALL be a 4:1 select driven only by registered sel.

Verification
REQ-035 Reset, then req = 1000 with out_ready = 1 -> next cycle grant = 1000, sel = 0, out_valid = 1; after 4 transfers the grant is re-issued to ch0 with no bubble.
REQ-036 req = 1111 held, out_ready = 1, MAX_HOLD = 4 -> grant sequence ch0, ch1, ch2, ch3, ch0, with each owner for 4 cycles and out_data = in[sel] every cycle.
REQ-037 Owner ch2 granted, out_ready = 0 for 5 cycles -> grant stays 0010, count frozen, busy = 1.
REQ-038 Owner ch1 drops req after 2 transfers while req[3] = 1 -> out_valid = 0 that cycle; next cycle grant = 0001 (ch3).
REQ-039 rst_n asserted low mid-grant on ch2 -> grant = 0, out_valid = 0 immediately; after release with req = 0110, the first grant goes to ch1.
REQ-040 Owner ch3 with only req[0] pending at release -> wrap-around grant to ch0 the next cycle.
